mmio_uart_tx: RTL and testbench

- Memory-mapped UART transmitter that sits on the CPU data bus as a responder. It is the target end of the cpu's mem_addr / mem_wr_sig / mem_wr_data / mem_rd_data interface.
- Decodes its own address window and accepts bytes written by the CPU into a TX FIFO.
- Serialises FIFO bytes as 8N1 frames on a single tx line.
- The top level muxes mem_rd_data between ram and this block using sel.

---
 rtl/mmio_uart_tx.sv | 189 ++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO, sitting on the CPU data bus.
// Define UART_TX_PARITY_EN to add an even-parity bit (11-bit frames).
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0001_0000,
  parameter int          FIFO_DEPTH   = 8,
  parameter int          CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] mem_addr,
  input  logic        mem_wr_sig,
  input  logic [31:0] mem_wr_data,
  output logic [31:0] mem_rd_data,
  output logic        sel,
  output logic        tx
);

  localparam int         PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);
`ifdef UART_TX_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [4:0]    r_count;
  logic          r_ovf;
  logic [15:0]   r_baud;
  state_t        r_state;
  logic [7:0]    r_shift;
  logic [15:0]   r_bit_div, r_cnt;
  logic [2:0]    r_bit_idx;
  logic          r_parity;
  logic          r_tx;

  logic        w_sel, w_wr, w_push_req, w_push, w_pop, w_full, w_empty, w_bit_end;
  logic [1:0]  w_off;
  logic [7:0]  w_head;
  logic [15:0] w_div_eff;
  logic [31:0] w_status;
  logic        w_unused;

  assign w_sel      = (mem_addr[31:4] == BASE_ADDR[31:4]);
  assign w_off      = mem_addr[3:2];
  assign w_wr       = mem_wr_sig & w_sel;
  assign w_push_req = w_wr & (w_off == 2'd0);
  assign w_full     = (r_count == DEPTH_C);
  assign w_empty    = (r_count == 5'd0);
  assign w_bit_end  = (r_cnt == 16'd0);
  assign w_head     = r_mem[r_rd_ptr];
  assign w_div_eff  = (r_baud == 16'd0) ? 16'd1 : r_baud;
  // Pops happen only from IDLE or on the last STOP cycle (back-to-back frames).
  assign w_pop      = !w_empty && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_status   = {22'd0, PAR_EN, r_count, r_ovf, (r_state != S_IDLE), w_empty, w_full};
  assign w_unused   = ^{mem_addr[1:0], mem_wr_data[31:16], r_parity};

  assign sel = w_sel;
  assign tx  = r_tx;

  always_comb begin
    mem_rd_data = 32'd0;
    if (w_sel) begin
      case (w_off)
        2'd1:    mem_rd_data = w_status;
        2'd2:    mem_rd_data = {16'd0, r_baud};
        default: mem_rd_data = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= mem_wr_data[7:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= 5'd0;
      r_ovf    <= 1'b0;
      r_baud   <= 16'(CLKS_PER_BIT);
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 5'd1;
        2'b01:   r_count <= r_count - 5'd1;
        default: r_count <= r_count;
      endcase
      if (w_push_req && w_full && !w_pop)  r_ovf <= 1'b1;
      else if (w_wr && (w_off == 2'd1))    r_ovf <= 1'b0;
      if (w_wr && (w_off == 2'd2)) r_baud <= mem_wr_data[15:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_tx      <= 1'b1;
      r_shift   <= 8'd0;
      r_bit_div <= 16'd1;
      r_cnt     <= 16'd0;
      r_bit_idx <= 3'd0;
      r_parity  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift   <= w_head;
            r_parity  <= ^w_head;
            r_bit_div <= w_div_eff;
            r_cnt     <= w_div_eff - 16'd1;
            r_tx      <= 1'b0;
            r_state   <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_cnt     <= r_bit_div - 16'd1;
            r_bit_idx <= 3'd0;
            r_tx      <= r_shift[0];
            r_state   <= S_DATA;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_cnt <= r_bit_div - 16'd1;
            if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              r_tx    <= r_parity;
              r_state <= S_PARITY;
`else
              r_tx    <= 1'b1;
              r_state <= S_STOP;
`endif
            end else begin
              r_shift   <= r_shift >> 1;
              r_tx      <= r_shift[1];
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            r_cnt   <= r_bit_div - 16'd1;
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
`endif
        S_STOP: begin
          if (w_bit_end) begin
            if (w_pop) begin
              r_shift   <= w_head;
              r_parity  <= ^w_head;
              r_bit_div <= w_div_eff;
              r_cnt     <= w_div_eff - 16'd1;
              r_tx      <= 1'b0;
              r_state   <= S_START;
            end else begin
              r_tx    <= 1'b1;
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: frame-level model compared every cycle plus directed literal checks.
module tb_mmio_uart_tx;
  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam int          DEPTH = 8;
  localparam int          CPB   = 16;
`ifdef UART_TX_PARITY_EN
  localparam int   NB  = 11;
  localparam logic PAR = 1'b1;
`else
  localparam int   NB  = 10;
  localparam logic PAR = 1'b0;
`endif
  localparam logic [31:0] PBIT = {22'd0, PAR, 9'd0};

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] mem_addr = 32'd0;
  logic        mem_wr_sig = 1'b0;
  logic [31:0] mem_wr_data = 32'd0;
  logic [31:0] mem_rd_data;
  logic        sel;
  logic        tx;

  always #5 clk = ~clk;

  mmio_uart_tx #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset_n(reset_n), .mem_addr(mem_addr), .mem_wr_sig(mem_wr_sig),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .sel(sel), .tx(tx)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: a byte queue and the current frame as a list of line levels, indexed by elapsed cycles.
  int   m_q[$];
  int   m_baud = CPB;
  bit   m_ovf  = 1'b0;
  bit   m_act  = 1'b0;
  int   m_div  = 1;
  int   m_pos  = 0;
  int   m_len  = 0;
  bit   m_bits[11];

  task automatic model_reset();
    m_q.delete();
    m_baud = CPB;
    m_ovf  = 1'b0;
    m_act  = 1'b0;
  endtask

  task automatic model_step();
    int  had, off, b;
    bit  ending, pop, insel, req, full;
    had    = m_q.size();
    ending = m_act && (m_pos == m_len - 1);
    pop    = (had > 0) && (!m_act || ending);
    insel  = (mem_addr[31:4] == BASE[31:4]);
    off    = int'(mem_addr[3:2]);
    req    = mem_wr_sig && insel && (off == 0);
    full   = (had == DEPTH);
    if (m_act) begin
      m_pos++;
      if (ending) m_act = 1'b0;
    end
    if (pop) begin
      b = m_q.pop_front();
      m_div = (m_baud == 0) ? 1 : m_baud;
      m_bits[0] = 1'b0;
      for (int k = 0; k < 8; k++) m_bits[k+1] = b[k];
      m_bits[9]  = (NB == 11) ? ^b[7:0] : 1'b1;
      m_bits[10] = 1'b1;
      m_len = NB * m_div;
      m_pos = 0;
      m_act = 1'b1;
    end
    if (req) begin
      if (!full || pop) m_q.push_back(int'(mem_wr_data[7:0]));
      else m_ovf = 1'b1;
    end
    if (mem_wr_sig && insel && off == 1) m_ovf = 1'b0;
    if (mem_wr_sig && insel && off == 2) m_baud = int'(mem_wr_data[15:0]);
  endtask

  function automatic logic model_tx();
    return m_act ? m_bits[m_pos / m_div] : 1'b1;
  endfunction

  function automatic logic [31:0] model_status();
    int n;
    n = m_q.size();
    return {22'd0, PAR, 5'(n), m_ovf, m_act, (n == 0), (n == DEPTH)};
  endfunction

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) model_reset();
    else          model_step();
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) chk("tx_vs_model", 32'(tx), 32'(model_tx()));
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic wr_one(input logic [31:0] a, input logic [31:0] d);
    mem_addr = a; mem_wr_data = d; mem_wr_sig = 1'b1;
    @(negedge clk);
    mem_wr_sig = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    mem_addr = a;
    #1;
    d = mem_rd_data;
  endtask

  int          exp_a5[11];
  int          i;
  logic [31:0] st;

  initial begin
    exp_a5 = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1};
    if (NB == 11) exp_a5[9] = 0;

    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    cmp_en  = 1'b1;
    @(negedge clk);

    // reset state
    chk("reset_tx", 32'(tx), 32'd1);
    rd(BASE + 32'h4, st); chk("reset_status", st, 32'h2 | PBIT);
    chk("reset_status_model", st, model_status());
    rd(BASE + 32'h8, st); chk("reset_baud", st, 32'd16);
    rd(32'h0000_0000, st); chk("unsel_rd", st, 32'd0); chk("unsel_sel", 32'(sel), 32'd0);
    rd(BASE + 32'h4, st); chk("sel_in_window", 32'(sel), 32'd1);

    // single 0xA5 frame at div 4, mid-bit samples
    @(negedge clk);
    wr_one(BASE + 32'h8, 32'd4);
    wr_one(BASE, 32'hA5);
    mem_addr = BASE + 32'h4;
    for (i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      st = mem_rd_data;
      if (i >= 2 && ((i - 2) % 4) == 0 && ((i - 2) / 4) < NB)
        chk("a5_bit", 32'(tx), 32'(exp_a5[(i - 2) / 4]));
      if (st[2] == 1'b0) break;
    end
    chk("a5_frame_len", 32'(i), 32'(NB * 4));
    chk("a5_idle_tx", 32'(tx), 32'd1);

    // back-to-back bytes, no idle gap
    @(negedge clk);
    mem_addr = BASE; mem_wr_data = 32'h55; mem_wr_sig = 1'b1;
    @(negedge clk);
    mem_wr_data = 32'h0F;
    @(negedge clk);
    mem_wr_sig = 1'b0; mem_addr = BASE + 32'h4;
    for (i = 0; i < 400; i++) begin
      #1;
      st = mem_rd_data;
      if (i == NB * 4)     chk("b2b_second_start", 32'(tx), 32'd0);
      if (i == NB * 4 - 1) chk("b2b_first_stop", 32'(tx), 32'd1);
      if (st[2] == 1'b0) break;
      @(negedge clk);
    end
    chk("b2b_total_len", 32'(i), 32'(2 * NB * 4));

    // BAUD_DIV change mid-frame applies only to the next frame
    @(negedge clk);
    mem_addr = BASE; mem_wr_data = 32'h3C; mem_wr_sig = 1'b1;
    @(negedge clk);
    mem_wr_data = 32'h81;
    @(negedge clk);
    mem_wr_sig = 1'b0; mem_addr = BASE + 32'h4;
    for (i = 0; i < 600; i++) begin
      if (i == 10) begin
        mem_addr = BASE + 32'h8; mem_wr_data = 32'd8; mem_wr_sig = 1'b1;
      end else if (i == 11) begin
        mem_wr_sig = 1'b0; mem_addr = BASE + 32'h4;
      end
      #1;
      st = mem_rd_data;
      if (i == NB * 4)     chk("baud_next_start", 32'(tx), 32'd0);
      if (i == NB * 4 + 4) chk("baud_next_start_long", 32'(tx), 32'd0);
      if (i != 10 && st[2] == 1'b0) break;
      @(negedge clk);
    end
    chk("baud_total_len", 32'(i), 32'(NB * 4 + NB * 8));

    // stall with a slow divider and overfill the FIFO
    @(negedge clk);
    wr_one(BASE + 32'h8, 32'd1000);
    for (int k = 0; k < 10; k++) begin
      mem_addr = BASE; mem_wr_data = 32'(k + 1); mem_wr_sig = 1'b1;
      @(negedge clk);
    end
    mem_wr_sig = 1'b0;
    rd(BASE + 32'h4, st);
    chk("stall_status", st, 32'h8D | PBIT);
    chk("stall_status_model", st, model_status());
    chk("stall_tx_start", 32'(tx), 32'd0);
    @(negedge clk);
    wr_one(BASE + 32'h4, 32'd0);
    rd(BASE + 32'h4, st);
    chk("ovf_clear_status", st, 32'h85 | PBIT);

    // reset in the middle of a frame
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("rst_tx_stall", 32'(tx), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    wr_one(BASE + 32'h8, 32'd4);
    mem_addr = BASE; mem_wr_data = 32'hF0; mem_wr_sig = 1'b1;
    @(negedge clk);
    mem_wr_data = 32'h77;
    @(negedge clk);
    mem_wr_sig = 1'b0; mem_addr = BASE + 32'h4;
    repeat (5) @(negedge clk);
    #1;
    chk("pre_reset_data_bit", 32'(tx), 32'd0);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_rst_tx", 32'(tx), 32'd1);
    chk("async_rst_status", mem_rd_data, 32'h2 | PBIT);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    wr_one(32'h0002_0000, 32'h11);
    wr_one(BASE + 32'hC, 32'h22);
    repeat (60) @(negedge clk);
    rd(BASE + 32'h4, st);
    chk("post_reset_quiet_tx", 32'(tx), 32'd1);
    chk("post_reset_status", st, 32'h2 | PBIT);
    rd(BASE + 32'hC, st);
    chk("reg_c_reads_zero", st, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
